// File: rtl/cache_pkg.sv
// Shared types and derived-width helpers for the blocking read-cache refill controller.
package cache_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StResp,
    StMissAr,
    StRefill,
    StTagWr
  } state_e;

  function automatic int unsigned calc_addr_lsb(int unsigned dw, int unsigned bk);
    return $clog2(dw * bk / 8);
  endfunction

  function automatic int unsigned calc_line_w(int unsigned cl);
    return $clog2(cl);
  endfunction

  function automatic int unsigned calc_beats(int unsigned dw, int unsigned bk);
    return dw * bk / 64;
  endfunction

  localparam int unsigned ADDR_LSB = calc_addr_lsb(1024, 4);
  localparam int unsigned LINE_W   = calc_line_w(256);
  localparam int unsigned BEATS    = calc_beats(1024, 4);

  // Tag is everything above the line index; callers zero-extend or truncate to TAG_W.
  function automatic logic [31:0] addr_tag(logic [31:0] addr, int unsigned shift);
    return addr >> shift;
  endfunction

endpackage

// File: rtl/cache_tag_cmp.sv
// Combinational tag compare: hit detection (lowest way wins) and first-invalid way search.
module cache_tag_cmp #(
  parameter int unsigned CB    = 1,
  parameter int unsigned TAG_W = 32
) (
  input  logic [CB-1:0]       valid_i,
  input  logic [TAG_W*CB-1:0] tag_rd_i,
  input  logic [TAG_W-1:0]    tag_i,
  output logic                hit_o,
  output logic [CB-1:0]       hit_way_o,
  output logic [CB-1:0]       inv_way_o
);

  // Descending scan so the lowest matching / invalid way is the one left standing.
  always_comb begin
    hit_o     = 1'b0;
    hit_way_o = '0;
    inv_way_o = '0;
    for (int w = CB - 1; w >= 0; w--) begin
      if (valid_i[w] && (tag_rd_i[TAG_W*w +: TAG_W] == tag_i)) begin
        hit_o        = 1'b1;
        hit_way_o    = '0;
        hit_way_o[w] = 1'b1;
      end
      if (!valid_i[w]) begin
        inv_way_o    = '0;
        inv_way_o[w] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Blocking read-cache controller: lookup, line refill over a 64-bit burst bus, tag write, replay.
// Optional hit/miss counters are built when CACHE_REFILL_PERF_EN is defined.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned DW    = 1024,
  parameter int unsigned BK    = 4,
  parameter int unsigned CB    = 1,
  parameter int unsigned CL    = 256,
  parameter int unsigned TAG_W = 32
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [63:0]              rsp_data,
  input  logic                     flush_req,
  output logic                     flush_ack,
  output logic                     mem_ar_valid,
  input  logic                     mem_ar_ready,
  output logic [31:0]              mem_ar_addr,
  input  logic                     mem_r_valid,
  output logic                     mem_r_ready,
  input  logic [63:0]              mem_r_data,
  output logic [31:0]              cache_addr,
  output logic [CB-1:0]            cache_en_w,
  output logic [CB-1:0]            cache_en_r,
  output logic [7:0]               cache_info_wstrb,
  output logic [63:0]              cache_info_w,
  input  logic [64*CB-1:0]         cache_info_r,
  output logic [31:0]              tag_addr,
  output logic [CB-1:0]            tag_en_w,
  output logic [CB-1:0]            tag_en_r,
  output logic [(TAG_W+7)/8-1:0]   tag_info_wstrb,
  output logic [TAG_W-1:0]         tag_info_w,
  input  logic [TAG_W*CB-1:0]      tag_info_r,
  output logic [31:0]              perf_hit_cnt,
  output logic [31:0]              perf_miss_cnt
);

  localparam int unsigned AddrLsb = calc_addr_lsb(DW, BK);
  localparam int unsigned LineW   = calc_line_w(CL);
  localparam int unsigned Beats   = calc_beats(DW, BK);
  localparam int unsigned BeatW   = $clog2(Beats);
  localparam int unsigned PtrW    = (CB > 1) ? $clog2(CB) : 1;

  state_e                 state_q, state_d;
  logic [31:0]            addr_q, addr_d;
  logic [BeatW-1:0]       beat_q, beat_d;
  logic [CB-1:0]          victim_q, victim_d;
  logic [PtrW-1:0]        ptr_q, ptr_d;
  logic [CB-1:0][CL-1:0]  valid_q, valid_d;
  logic                   req_ready_q, req_ready_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [63:0]            rsp_data_q, rsp_data_d;
  logic                   flush_ack_q, flush_ack_d;
  logic                   ar_valid_q, ar_valid_d;
  logic [31:0]            ar_addr_q, ar_addr_d;
  logic                   r_ready_q, r_ready_d;

  logic [LineW-1:0]       idx;
  logic [TAG_W-1:0]       req_tag;
  logic [31:0]            line_base;
  logic [CB-1:0]          way_valid, hit_way, inv_way, rr_way;
  logic                   hit, accept;
  logic [63:0]            hit_data;

  assign idx       = addr_q[AddrLsb +: LineW];
  assign req_tag   = TAG_W'(addr_tag(addr_q, AddrLsb + LineW));
  assign line_base = {addr_q[31:AddrLsb], {AddrLsb{1'b0}}};
  assign rr_way    = CB'(1) << ptr_q;
  // A flush takes the IDLE cycle, so a concurrent request is not acknowledged.
  assign req_ready = req_ready_q & ~flush_req;
  assign accept    = req_valid & req_ready;

  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign flush_ack    = flush_ack_q;
  assign mem_ar_valid = ar_valid_q;
  assign mem_ar_addr  = ar_addr_q;
  assign mem_r_ready  = r_ready_q;

  always_comb begin
    way_valid = '0;
    hit_data  = '0;
    for (int w = 0; w < CB; w++) begin
      way_valid[w] = valid_q[w][idx];
      if (hit_way[w]) hit_data = hit_data | cache_info_r[64*w +: 64];
    end
  end

  cache_tag_cmp #(
    .CB    (CB),
    .TAG_W (TAG_W)
  ) u_tag_cmp (
    .valid_i   (way_valid),
    .tag_rd_i  (tag_info_r),
    .tag_i     (req_tag),
    .hit_o     (hit),
    .hit_way_o (hit_way),
    .inv_way_o (inv_way)
  );

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    beat_d           = beat_q;
    victim_d         = victim_q;
    ptr_d            = ptr_q;
    valid_d          = valid_q;
    req_ready_d      = req_ready_q;
    rsp_valid_d      = rsp_valid_q;
    rsp_data_d       = rsp_data_q;
    flush_ack_d      = 1'b0;
    ar_valid_d       = ar_valid_q;
    ar_addr_d        = ar_addr_q;
    r_ready_d        = r_ready_q;
    cache_addr       = '0;
    cache_en_w       = '0;
    cache_en_r       = '0;
    cache_info_wstrb = '0;
    cache_info_w     = '0;
    tag_addr         = '0;
    tag_en_w         = '0;
    tag_en_r         = '0;
    tag_info_wstrb   = '0;
    tag_info_w       = '0;

    unique case (state_q)
      StIdle: begin
        req_ready_d = 1'b1;
        if (flush_req) begin
          valid_d     = '0;
          flush_ack_d = 1'b1;
        end else if (accept) begin
          addr_d      = req_addr;
          cache_en_r  = '1;
          tag_en_r    = '1;
          cache_addr  = req_addr;
          tag_addr    = req_addr;
          req_ready_d = 1'b0;
          state_d     = StLookup;
        end
      end
      StLookup: begin
        if (hit) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = hit_data;
          state_d     = StResp;
        end else begin
          victim_d   = (|inv_way) ? inv_way : rr_way;
          ar_valid_d = 1'b1;
          ar_addr_d  = line_base;
          state_d    = StMissAr;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = StIdle;
        end
      end
      StMissAr: begin
        if (mem_ar_ready) begin
          ar_valid_d = 1'b0;
          ar_addr_d  = '0;
          beat_d     = '0;
          r_ready_d  = 1'b1;
          state_d    = StRefill;
        end
      end
      StRefill: begin
        if (mem_r_valid) begin
          cache_en_w       = victim_q;
          cache_addr       = line_base + (32'(beat_q) << 3);
          cache_info_wstrb = 8'hFF;
          cache_info_w     = mem_r_data;
          beat_d           = beat_q + 1'b1;
          if (beat_q == BeatW'(Beats - 1)) begin
            r_ready_d = 1'b0;
            state_d   = StTagWr;
          end
        end
      end
      StTagWr: begin
        tag_addr       = addr_q;
        tag_en_w       = victim_q;
        tag_info_wstrb = '1;
        tag_info_w     = req_tag;
        for (int w = 0; w < CB; w++) begin
          if (victim_q[w]) valid_d[w][idx] = 1'b1;
        end
        if (CB > 1) ptr_d = (ptr_q == PtrW'(CB - 1)) ? '0 : ptr_q + 1'b1;
        else        ptr_d = '0;
        cache_en_r = '1;
        tag_en_r   = '1;
        cache_addr = addr_q;
        state_d    = StLookup;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      beat_q      <= '0;
      victim_q    <= '0;
      ptr_q       <= '0;
      valid_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      flush_ack_q <= 1'b0;
      ar_valid_q  <= 1'b0;
      ar_addr_q   <= '0;
      r_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      beat_q      <= beat_d;
      victim_q    <= victim_d;
      ptr_q       <= ptr_d;
      valid_q     <= valid_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      flush_ack_q <= flush_ack_d;
      ar_valid_q  <= ar_valid_d;
      ar_addr_q   <= ar_addr_d;
      r_ready_q   <= r_ready_d;
    end
  end

`ifdef CACHE_REFILL_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic        replay_q;

  // A LOOKUP straight after TAG_WR is the replay and is not a core-visible hit.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == StLookup) begin
      if (hit && !replay_q) hit_cnt_d = hit_cnt_q + 32'd1;
      if (!hit)             miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      replay_q   <= 1'b0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      replay_q   <= (state_q == StTagWr);
    end
  end

  assign perf_hit_cnt  = hit_cnt_q;
  assign perf_miss_cnt = miss_cnt_q;
`else
  assign perf_hit_cnt  = '0;
  assign perf_miss_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: directed plan plus randomized loads vs a line model.
module tb_cache_refill_ctrl;

  localparam int unsigned BEATS = 64;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, flush_req, flush_ack;
  logic [31:0] req_addr, mem_ar_addr, cache_addr, tag_addr, perf_hit_cnt, perf_miss_cnt;
  logic [63:0] rsp_data, mem_r_data, cache_info_w, cache_info_r;
  logic        mem_ar_valid, mem_ar_ready, mem_r_valid, mem_r_ready;
  logic [0:0]  cache_en_w, cache_en_r, tag_en_w, tag_en_r;
  logic [7:0]  cache_info_wstrb;
  logic [3:0]  tag_info_wstrb;
  logic [31:0] tag_info_w, tag_info_r;

  cache_refill_ctrl dut (
    .CLK              (CLK),
    .RSTn             (RSTn),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_data         (rsp_data),
    .flush_req        (flush_req),
    .flush_ack        (flush_ack),
    .mem_ar_valid     (mem_ar_valid),
    .mem_ar_ready     (mem_ar_ready),
    .mem_ar_addr      (mem_ar_addr),
    .mem_r_valid      (mem_r_valid),
    .mem_r_ready      (mem_r_ready),
    .mem_r_data       (mem_r_data),
    .cache_addr       (cache_addr),
    .cache_en_w       (cache_en_w),
    .cache_en_r       (cache_en_r),
    .cache_info_wstrb (cache_info_wstrb),
    .cache_info_w     (cache_info_w),
    .cache_info_r     (cache_info_r),
    .tag_addr         (tag_addr),
    .tag_en_w         (tag_en_w),
    .tag_en_r         (tag_en_r),
    .tag_info_wstrb   (tag_info_wstrb),
    .tag_info_w       (tag_info_w),
    .tag_info_r       (tag_info_r),
    .perf_hit_cnt     (perf_hit_cnt),
    .perf_miss_cnt    (perf_miss_cnt)
  );

  always #5 CLK = ~CLK;

  // cache_mem and tag memory stand-ins (synchronous read, write-first on a same-cycle collision)
  logic [63:0] data_mem [0:16383];
  logic [31:0] tag_mem  [0:255];
  always @(posedge CLK) begin
    if (cache_en_w[0]) data_mem[cache_addr[16:3]] <= cache_info_w;
    if (cache_en_r[0])
      cache_info_r <= (cache_en_w[0] && cache_addr[16:3] == cache_addr[16:3]) ? cache_info_w
                                                                             : data_mem[cache_addr[16:3]];
    if (tag_en_w[0]) tag_mem[tag_addr[16:9]] <= tag_info_w;
    if (tag_en_r[0]) tag_info_r <= tag_en_w[0] ? tag_info_w : tag_mem[tag_addr[16:9]];
  end

  // Memory read-bus responder: beat k carries 0xA5A5_0000_0000_0000 + k.
  int          beat_k, k_nxt, ar_cnt = 0, wr_cnt = 0;
  bit          burst_on, on_nxt, tog, gap_mode = 0;
  logic [31:0] last_ar = '0;
  always_comb begin
    k_nxt  = beat_k;
    on_nxt = burst_on;
    if (mem_r_valid && mem_r_ready) begin
      k_nxt = beat_k + 1;
      if (k_nxt == BEATS) on_nxt = 1'b0;
    end
    if (mem_ar_valid && mem_ar_ready) begin
      on_nxt = 1'b1;
      k_nxt  = 0;
    end
  end
  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      burst_on    <= 1'b0;
      beat_k      <= 0;
      tog         <= 1'b0;
      mem_r_valid <= 1'b0;
      mem_r_data  <= '0;
    end else begin
      if (mem_ar_valid && mem_ar_ready) begin
        ar_cnt  <= ar_cnt + 1;
        last_ar <= mem_ar_addr;
      end
      if (cache_en_w[0]) wr_cnt <= wr_cnt + 1;
      burst_on    <= on_nxt;
      beat_k      <= k_nxt;
      tog         <= ~tog;
      mem_r_valid <= on_nxt && (!gap_mode || tog);
      mem_r_data  <= 64'hA5A5_0000_0000_0000 + 64'(k_nxt);
    end
  end

  // Reference model: one way, per-index valid + tag, expected counter values.
  bit          mv [0:255];
  logic [14:0] mt [0:255];
  int          exp_hits = 0, exp_miss = 0;
  int          n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) mv[i] = 1'b0;
  endtask

  task automatic check_outs_zero(input string name);
    logic any_out;
    any_out = |{req_ready, rsp_valid, rsp_data, flush_ack, mem_ar_valid, mem_ar_addr, mem_r_ready,
                cache_addr, cache_en_w, cache_en_r, cache_info_wstrb, cache_info_w, tag_addr,
                tag_en_w, tag_en_r, tag_info_wstrb, tag_info_w, perf_hit_cnt, perf_miss_cnt};
    check(name, 64'(any_out), 64'd0);
  endtask

  task automatic check_perf();
`ifdef CACHE_REFILL_PERF_EN
    check("perf_hit", 64'(perf_hit_cnt), 64'(exp_hits));
    check("perf_miss", 64'(perf_miss_cnt), 64'(exp_miss));
`else
    check("perf_hit_tied", 64'(perf_hit_cnt), 64'd0);
    check("perf_miss_tied", 64'(perf_miss_cnt), 64'd0);
`endif
  endtask

  task automatic do_load(input logic [31:0] a, input int hold);
    logic [7:0]  idx;
    logic [63:0] exp_d;
    bit          h;
    int          n, lat, ar0, wr0;
    idx   = a[16:9];
    h     = mv[idx] && (mt[idx] == a[31:17]);
    exp_d = 64'hA5A5_0000_0000_0000 + 64'(a[8:3]);
    @(negedge CLK);
    req_valid = 1'b1;
    req_addr  = a;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("req_ready_timeout", 64'(n >= 50), 64'd0);
    ar0 = ar_cnt;
    wr0 = wr_cnt;
    @(negedge CLK);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 1000) begin
      @(negedge CLK);
      lat++;
    end
    check("rsp_timeout", 64'(lat >= 1000), 64'd0);
    check("rsp_data", rsp_data, exp_d);
    check("miss_flag", 64'(ar_cnt - ar0), h ? 64'd0 : 64'd1);
    if (h) begin
      check("hit_latency", 64'(lat), 64'd2);
    end else begin
      check("ar_addr", 64'(last_ar), 64'({a[31:9], 9'b0}));
      check("beats_written", 64'(wr_cnt - wr0), 64'(BEATS));
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_data", rsp_data, exp_d);
      check("hold_req_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
    check("rsp_drop", 64'(rsp_valid), 64'd0);
    if (h) begin
      exp_hits++;
    end else begin
      exp_miss++;
      mv[idx] = 1'b1;
      mt[idx] = a[31:17];
    end
  endtask

  initial begin
    int          n, wr0;
    logic [31:0] a;
    RSTn         = 1'b1;
    req_valid    = 1'b0;
    req_addr     = '0;
    rsp_ready    = 1'b0;
    flush_req    = 1'b0;
    mem_ar_ready = 1'b1;
    model_clear();
    #2 RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    check_outs_zero("reset_outputs");
    RSTn = 1'b1;
    check("req_ready_at_release", 64'(req_ready), 64'd0);
    @(negedge CLK);
    check("req_ready_after_release", 64'(req_ready), 64'd1);
    check_perf();

    do_load(32'h8000_0010, 0);  // cold miss
    do_load(32'h8000_0018, 0);  // hit in the refilled line
    check_perf();
    do_load(32'h8002_0010, 0);  // same index, new tag: eviction
    do_load(32'h8000_0010, 0);  // evicted line misses again

    @(negedge CLK);
    flush_req = 1'b1;
    @(negedge CLK);
    flush_req = 1'b0;
    check("flush_ack_pulse", 64'(flush_ack), 64'd1);
    @(negedge CLK);
    check("flush_ack_drop", 64'(flush_ack), 64'd0);
    model_clear();
    do_load(32'h8002_0010, 0);  // miss after flush
    do_load(32'h8002_0018, 5);  // hit with back-pressure

    // Reset in the middle of a gapped refill.
    gap_mode = 1;
    @(negedge CLK);
    req_valid = 1'b1;
    req_addr  = 32'h8000_0010;
    wr0 = wr_cnt;
    @(negedge CLK);
    req_valid = 1'b0;
    n = 0;
    while ((wr_cnt - wr0) < 10 && n < 500) begin
      @(negedge CLK);
      n++;
    end
    check("refill_progress_timeout", 64'(n >= 500), 64'd0);
    RSTn = 1'b0;
    #1;
    check_outs_zero("midrefill_reset_outputs");
    repeat (2) @(negedge CLK);
    RSTn     = 1'b1;
    gap_mode = 0;
    model_clear();
    exp_hits = 0;
    exp_miss = 0;
    @(negedge CLK);
    do_load(32'h8000_0010, 0);  // partial line must not hit

    for (int i = 0; i < 30; i++) begin
      gap_mode = (i >= 15);
      a = ($urandom_range(0, 1) != 0) ? 32'h8002_0000 : 32'h8000_0000;
      a = a | (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 63)) << 3);
      do_load(a, int'($urandom_range(0, 2)));
    end
    check_perf();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
